// File: rtl/serial_and_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_and_scheduler_if                                           |
// | Brief  : Request/operand/result bundle between requesters and the         |
// |          serial AND scheduler.                                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface serial_and_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;

    modport master (
        output req, a_bus, b_bus,
        input  gnt, busy, done, result
    );

    modport slave (
        input  req, a_bus, b_bus,
        output gnt, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/serial_and_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_and_scheduler                                              |
// | Brief  : Round-robin arbiter that streams one requester's operands LSB-    |
// |          first through a single shared 1-bit AND gate.                     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module serial_and_scheduler #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int GATE_DELAY = 0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_and_scheduler_if.slave bus
);
    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_PTR_W:0] c_NREQ = (c_PTR_W + 1)'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_win;
    logic [c_PTR_W-1:0] w_win;
    logic               w_found;
    logic [c_PTR_W:0]   w_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [NREQ-1:0]    r_gnt;
    wire logic          w_gate;

    // Search starts at r_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W + 1)'(i);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && bus.req[w_idx[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_CNT_W'(WIDTH - 1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_win    <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_gnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win <= w_win;
                        r_gnt <= NREQ'(1) << w_win;
                        r_a   <= bus.a_bus[int'(w_win)*WIDTH +: WIDTH];
                        r_b   <= bus.b_bus[int'(w_win)*WIDTH +: WIDTH];
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    // Gate output enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
                    r_result <= {w_gate, r_result[WIDTH-1:1]};
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_win == c_PTR_W'(NREQ - 1)) ? '0 : r_win + 1'b1;
                end
                default: begin
                    r_gnt <= '0;
                end
            endcase
        end
    end

    // The one and only AND gate in the datapath.
    and #(GATE_DELAY) u_and_gate (w_gate, r_a[0], r_b[0]);

    assign bus.gnt    = r_gnt;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE) ? r_gnt : '0;
    assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_serial_and_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_serial_and_scheduler                                           |
// | Brief  : Directed bench with a transaction-level model of the scheduler.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_serial_and_scheduler;
    localparam int W = 8;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_and_scheduler_if #(.WIDTH(W), .NREQ(N)) bus ();

    serial_and_scheduler #(.WIDTH(W), .NREQ(N), .GATE_DELAY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation granted at edge count S shows done after edge S+W and
    // frees the scheduler at edge S+W+1.
    int         cyc;
    bit         m_active;
    int         m_ptr, m_win, m_start;
    logic [W-1:0] m_a, m_b, m_res;
    int         g_win[$];
    int         g_cyc[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_ptr    = 0;
            m_win    = 0;
            m_res    = '0;
            cyc      = 0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc == m_start + W) begin
                    m_res = m_a & m_b;
                end else if (cyc == m_start + W + 1) begin
                    m_active = 1'b0;
                    m_ptr    = (m_win + 1) % N;
                end
            end else if (bus.req != '0) begin
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = (m_ptr + i) % N;
                    if (bus.req[idx]) begin
                        m_win = idx;
                        break;
                    end
                end
                m_a      = bus.a_bus[m_win*W +: W];
                m_b      = bus.b_bus[m_win*W +: W];
                m_active = 1'b1;
                m_start  = cyc;
                g_win.push_back(m_win);
                g_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt",  32'(bus.gnt),  m_active ? (32'd1 << m_win) : 32'd0);
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("done", 32'(bus.done),
                (m_active && cyc == m_start + W) ? (32'd1 << m_win) : 32'd0);
            if (!m_active || cyc == m_start + W)
                chk("result", 32'(bus.result), 32'(m_res));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done == '0 && n < 40);
        if (bus.done == '0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=nonzero after %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.req = '0;
        g_win.delete();
        g_cyc.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [W-1:0] r2 [4];
        int seq3 [4];
        r2   = '{8'h08, 8'h04, 8'h02, 8'h01};
        seq3 = '{0, 2, 0, 2};
        bus.req   = '0;
        bus.a_bus = '0;
        bus.b_bus = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single request
        @(negedge clk);
        chk("rst_gnt",    32'(bus.gnt),    32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        bus.req = 4'b0001;
        bus.a_bus[0 +: W] = 8'hF0;
        bus.b_bus[0 +: W] = 8'h3C;
        @(negedge clk);
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        wait_done(n);
        chk("t1_latency", 32'(n), 32'd8);
        chk("t1_done",    32'(bus.done),   32'h1);
        chk("t1_result",  32'(bus.result), 32'h30);
        bus.req = '0;
        @(negedge clk);
        chk("t1_busy_low", 32'(bus.busy), 32'd0);
        chk("t1_held",     32'(bus.result), 32'h30);

        // 2: all four request, served in order 0..3 ten cycles apart
        do_reset();
        bus.a_bus = {4{8'hFF}};
        bus.b_bus = {8'h01, 8'h02, 8'h04, 8'h08};
        bus.req   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            chk("t2_done",   32'(bus.done),   32'd1 << i);
            chk("t2_result", 32'(bus.result), 32'(r2[i]));
            bus.req[i] = 1'b0;
        end
        chk("t2_ngrants", 32'(g_win.size()), 32'd4);
        if (g_win.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_order", 32'(g_win[i]), 32'(i));
            for (int i = 0; i < 3; i++) chk("t2_spacing", 32'(g_cyc[i+1] - g_cyc[i]), 32'd10);
        end

        // 3: requesters 0 and 2 held -> alternate
        do_reset();
        bus.a_bus = '0;
        bus.b_bus = '0;
        bus.a_bus[0 +: W] = 8'h0F;  bus.b_bus[0 +: W] = 8'hFF;
        bus.a_bus[16 +: W] = 8'hF0; bus.b_bus[16 +: W] = 8'h3C;
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_done(n);
            chk("t3_done",   32'(bus.done),   32'd1 << seq3[i]);
            chk("t3_result", 32'(bus.result), (seq3[i] == 0) ? 32'h0F : 32'h30);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);

        // 4: req dropped and operand changed mid-operation
        do_reset();
        bus.a_bus[8 +: W] = 8'hAA;
        bus.b_bus[8 +: W] = 8'hFF;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("t4_gnt", 32'(bus.gnt), 32'h2);
        repeat (2) @(negedge clk);
        bus.req = '0;
        bus.a_bus[8 +: W] = 8'h00;
        wait_done(n);
        chk("t4_done",   32'(bus.done),   32'h2);
        chk("t4_result", 32'(bus.result), 32'hAA);

        // 5: reset in the middle of an operation
        do_reset();
        bus.a_bus[0 +: W] = 8'hFF;
        bus.b_bus[0 +: W] = 8'hFF;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t5_gnt", 32'(bus.gnt), 32'h1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        bus.req = '0;
        #1;
        chk("t5_rst_gnt",    32'(bus.gnt),    32'd0);
        chk("t5_rst_busy",   32'(bus.busy),   32'd0);
        chk("t5_rst_done",   32'(bus.done),   32'd0);
        chk("t5_rst_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.a_bus[24 +: W] = 8'hC3;
        bus.b_bus[24 +: W] = 8'h0F;
        bus.req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt3", 32'(bus.gnt), 32'h8);
        wait_done(n);
        chk("t5_result", 32'(bus.result), 32'h03);
        bus.req = '0;
        @(negedge clk);

        // 6: complementary operands
        bus.a_bus[0 +: W] = 8'hAA;
        bus.b_bus[0 +: W] = 8'h55;
        bus.req = 4'b0001;
        wait_done(n);
        chk("t6_done",   32'(bus.done),   32'h1);
        chk("t6_result", 32'(bus.result), 32'h00);
        bus.req = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
